// File: rtl/gzip_compressor_top.sv
// rtl/gzip_compressor_top.sv - literal-only fixed-Huffman gzip member encoder, bytes in / 32-bit LE words out
module gzip_compressor_top #(
  parameter int SIMULATION = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic [7:0]  i_tdata,
  input  logic        i_tlast,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic [3:0]  o_tkeep
);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_TAIL, S_FLUSH} state_t;

  // gzip header bytes 0..7 (1F 8B 08 00, MTIME 0) packed little-endian
  localparam logic [63:0] HDR_LO = 64'h0000_0000_0008_8B1F;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // Huffman codes go out MSB-first, so return the code already bit-reversed
  function automatic logic [8:0] lit_rev(input logic [7:0] b);
    logic [8:0] c;
    logic [8:0] r;
    r = '0;
    if (b < 8'd144) begin
      c = {1'b0, b + 8'h30};
      for (int k = 0; k < 8; k++) r[k] = c[7-k];
    end else begin
      c = 9'h190 + {1'b0, b} - 9'd144;
      for (int k = 0; k < 9; k++) r[k] = c[8-k];
    end
    return r;
  endfunction

  function automatic logic [3:0] keep_of(input logic [6:0] n);
    case (n[5:3])
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  tstep_q, tstep_d;
  logic [63:0] acc_q, acc_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] bytes_q, bytes_d;
  logic [8:0]  pend_code_q, pend_code_d;
  logic [3:0]  pend_len_q, pend_len_d;
  logic        pend_last_q, pend_last_d;
  logic        ov_q, ov_d, ol_q, ol_d;
  logic [31:0] od_q, od_d;
  logic [3:0]  ok_q, ok_d;

  logic        can_take, mv, flush_last, in_fire, app_en, room;
  logic [6:0]  cnt_m, app_len;
  logic [63:0] acc_m, app_bits;
  logic [8:0]  in_rev;
  logic [3:0]  in_len;
  logic [2:0]  pad;

  logic sim_param_unused;
  assign sim_param_unused = (SIMULATION != 0);

  assign i_tready = !rst && ((state_q == S_IDLE) || (state_q == S_DATA && cnt_q <= 7'd55));
  assign o_tvalid = ov_q;
  assign o_tdata  = od_q;
  assign o_tlast  = ol_q;
  assign o_tkeep  = ok_q;

  always_comb begin
    can_take    = !ov_q || o_tready;
    flush_last  = (state_q == S_FLUSH) && (cnt_q <= 7'd32);
    mv          = can_take && ((state_q == S_FLUSH) || (cnt_q >= 7'd32));
    cnt_m       = mv ? (flush_last ? 7'd0 : cnt_q - 7'd32) : cnt_q;
    acc_m       = mv ? {32'd0, acc_q[63:32]} : acc_q;
    in_fire     = i_tready && i_tvalid;
    in_rev      = lit_rev(i_tdata);
    in_len      = (i_tdata < 8'd144) ? 4'd8 : 4'd9;
    pad         = 3'd1 - cnt_m[2:0];
    app_en      = 1'b0;
    app_bits    = '0;
    app_len     = '0;
    state_d     = state_q;
    tstep_d     = tstep_q;
    crc_d       = crc_q;
    bytes_d     = bytes_q;
    pend_code_d = pend_code_q;
    pend_len_d  = pend_len_q;
    pend_last_d = pend_last_q;

    case (state_q)
      S_HEADER: begin
        // bytes 8..9 (XFL 00, OS FF), BFINAL=1/BTYPE=01, then the held first literal
        app_bits = ({55'd0, pend_code_q} << 19) | 64'h3_FF00;
        app_len  = 7'd19 + {3'd0, pend_len_q};
      end
      S_DATA: begin
        app_bits = {55'd0, in_rev};
        app_len  = {3'd0, in_len};
      end
      S_TAIL: begin
        case (tstep_q)
          2'd0:    app_len = 7'd7 + {4'd0, pad};
          2'd1:    begin app_bits = {32'd0, ~crc_q}; app_len = 7'd32; end
          default: begin app_bits = {32'd0, bytes_q}; app_len = 7'd32; end
        endcase
      end
      default: ;
    endcase
    room = ({1'b0, cnt_m} + {1'b0, app_len}) <= 8'd64;

    case (state_q)
      S_IDLE: if (in_fire) begin
        state_d     = S_HEADER;
        crc_d       = crc_byte(32'hFFFF_FFFF, i_tdata);
        bytes_d     = 32'd1;
        pend_code_d = in_rev;
        pend_len_d  = in_len;
        pend_last_d = i_tlast;
      end
      S_HEADER: if (room) begin
        app_en  = 1'b1;
        state_d = pend_last_q ? S_TAIL : S_DATA;
        tstep_d = 2'd0;
      end
      S_DATA: if (in_fire) begin
        app_en  = 1'b1;
        crc_d   = crc_byte(crc_q, i_tdata);
        bytes_d = bytes_q + 32'd1;
        if (i_tlast) begin
          state_d = S_TAIL;
          tstep_d = 2'd0;
        end
      end
      S_TAIL: if (room) begin
        app_en  = 1'b1;
        tstep_d = tstep_q + 2'd1;
        if (tstep_q == 2'd2) state_d = S_FLUSH;
      end
      S_FLUSH: if (mv && flush_last) begin
        state_d = S_IDLE;
        crc_d   = 32'hFFFF_FFFF;
        bytes_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE && in_fire) begin
      acc_d = HDR_LO;
      cnt_d = 7'd64;
    end else if (app_en) begin
      acc_d = acc_m | (app_bits << cnt_m);
      cnt_d = cnt_m + app_len;
    end else begin
      acc_d = acc_m;
      cnt_d = cnt_m;
    end

    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    ok_d = ok_q;
    if (mv) begin
      ov_d = 1'b1;
      od_d = acc_q[31:0];
      ol_d = flush_last;
      ok_d = flush_last ? keep_of(cnt_q) : 4'b1111;
    end else if (o_tready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tstep_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      crc_q       <= 32'hFFFF_FFFF;
      bytes_q     <= '0;
      pend_code_q <= '0;
      pend_len_q  <= '0;
      pend_last_q <= 1'b0;
      ov_q        <= 1'b0;
      od_q        <= '0;
      ol_q        <= 1'b0;
      ok_q        <= '0;
    end else begin
      state_q     <= state_d;
      tstep_q     <= tstep_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      bytes_q     <= bytes_d;
      pend_code_q <= pend_code_d;
      pend_len_q  <= pend_len_d;
      pend_last_q <= pend_last_d;
      ov_q        <= ov_d;
      od_q        <= od_d;
      ol_q        <= ol_d;
      ok_q        <= ok_d;
    end
  end

endmodule

// File: tb/tb_gzip_compressor_top.sv
// tb/tb_gzip_compressor_top.sv - scoreboard bench for gzip_compressor_top
module tb_gzip_compressor_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tready, i_tvalid, i_tlast;
  logic [7:0]  i_tdata;
  logic        o_tready, o_tvalid, o_tlast;
  logic [31:0] o_tdata;
  logic [3:0]  o_tkeep;

  gzip_compressor_top #(.SIMULATION(0)) dut (
    .clk(clk), .rst(rst),
    .i_tready(i_tready), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tkeep(o_tkeep)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
  typedef struct {
    int           len;
    logic [383:0] text;
    bit           has_crc;
    logic [31:0]  crc;
    bit           has_defl;
    logic [15:0]  defl;
  } vec_t;

  word_t        exp_q[$];
  word_t        e;
  int           errors = 0;
  int           checks = 0;
  int           rdy_div = 1;
  int           rdy_k = 0;
  bit           sb_ignore = 1'b0;
  byte unsigned got_bytes[$], last_member[$];
  logic [31:0]  got_words[$], last_words[$];
  int           members = 0;
  byte unsigned mb[$];
  logic [7:0]   mcur;
  int           mn;

  logic        prev_ov, prev_or, prev_ol, prev_ir, prev_iv, prev_rst;
  logic [31:0] prev_od;
  logic [3:0]  prev_ok;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input byte unsigned p[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      c = c ^ {24'd0, p[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic put_bit(input logic b);
    mcur[mn] = b;
    mn++;
    if (mn == 8) begin
      mb.push_back(mcur);
      mcur = '0;
      mn = 0;
    end
  endtask

  // Builds the expected member byte by byte, then queues it as 32-bit words
  task automatic model_push(input byte unsigned p[$]);
    logic [79:0] hdr;
    logic [31:0] c;
    int code, len;
    word_t w;
    hdr = 80'hFF00_0000_0000_0008_8B1F;
    mb.delete();
    mcur = '0;
    mn = 0;
    for (int i = 0; i < 10; i++) mb.push_back(hdr[8*i +: 8]);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    foreach (p[i]) begin
      if (p[i] < 144) begin code = int'(p[i]) + 48;  len = 8; end
      else            begin code = int'(p[i]) + 256; len = 9; end
      for (int k = len - 1; k >= 0; k--) put_bit(code[k]);
    end
    for (int k = 0; k < 7; k++) put_bit(1'b0);
    while (mn != 0) put_bit(1'b0);
    c = ref_crc(p);
    for (int j = 0; j < 4; j++) mb.push_back(c[8*j +: 8]);
    c = p.size();
    for (int j = 0; j < 4; j++) mb.push_back(c[8*j +: 8]);
    for (int i = 0; i < mb.size(); i += 4) begin
      w.data = '0;
      w.keep = '0;
      for (int j = 0; j < 4; j++)
        if (i + j < mb.size()) begin
          w.data[8*j +: 8] = mb[i+j];
          w.keep[j] = 1'b1;
        end
      w.last = (i + 4 >= mb.size());
      exp_q.push_back(w);
    end
  endtask

  task automatic send_packet(input byte unsigned p[$], input int gap_pct, input bit with_last, input bit push_exp);
    int n;
    if (push_exp) model_push(p);
    foreach (p[i]) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        i_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      i_tvalid = 1'b1;
      i_tdata  = p[i];
      i_tlast  = with_last && (i == p.size() - 1);
      n = 0;
      @(negedge clk);
      while (!i_tready && n < 5000) begin
        n++;
        @(negedge clk);
      end
      if (!i_tready) begin
        check("in_handshake_timeout", 32'(i_tready), 32'd1);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30000) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_trailer(input string name, input logic [31:0] crc, input int len);
    int n;
    n = last_member.size();
    check({name, "_size"}, 32'(n >= 18), 32'd1);
    if (n >= 18) begin
      check({name, "_crc"}, {last_member[n-5], last_member[n-6], last_member[n-7], last_member[n-8]}, crc);
      check({name, "_isize"}, {last_member[n-1], last_member[n-2], last_member[n-3], last_member[n-4]}, 32'(len));
    end
  endtask

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy_k++;
      o_tready = (rdy_k % rdy_div) == 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      if (prev_ov && !prev_or) begin
        check("stall_valid", 32'(o_tvalid), 32'd1);
        check("stall_data", o_tdata, prev_od);
        check("stall_last_keep", {27'd0, o_tlast, o_tkeep}, {27'd0, prev_ol, prev_ok});
      end
      if (prev_ir && !prev_iv) check("itready_held", 32'(i_tready), 32'd1);
    end
    if (!rst && o_tvalid) begin
      if (!o_tlast) check("tkeep_nonlast", 32'(o_tkeep), 32'hF);
      else check("tkeep_last_contig", 32'(o_tkeep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111}), 32'd1);
    end
    if (!rst && o_tvalid && o_tready && !sb_ignore) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_word", o_tdata, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", o_tdata, e.data);
        check("sb_keep_last", {27'd0, o_tlast, o_tkeep}, {27'd0, e.last, e.keep});
      end
      for (int b = 0; b < 4; b++) if (o_tkeep[b]) got_bytes.push_back(o_tdata[8*b +: 8]);
      got_words.push_back(o_tdata);
      if (o_tlast) begin
        last_member = got_bytes;
        last_words  = got_words;
        got_bytes.delete();
        got_words.delete();
        members++;
      end
    end
    prev_ov = o_tvalid; prev_or = o_tready; prev_ol = o_tlast; prev_od = o_tdata;
    prev_ok = o_tkeep;  prev_ir = i_tready; prev_iv = i_tvalid; prev_rst = rst;
  end

  initial begin
    vec_t         tbl[5];
    byte unsigned p[$];
    logic [31:0]  a_words[6];
    int           n, m0, len;

    i_tvalid = 1'b0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    tbl[0] = '{1,  384'("a"),         1'b1, 32'hE8B7_BE43, 1'b1, 16'h4B04};
    tbl[1] = '{3,  384'("abc"),       1'b1, 32'h3524_41C2, 1'b0, 16'h0};
    tbl[2] = '{9,  384'("123456789"), 1'b1, 32'hCBF4_3926, 1'b0, 16'h0};
    tbl[3] = '{43, 384'("The quick brown fox jumps over the lazy dog"), 1'b1, 32'h414F_A339, 1'b0, 16'h0};
    tbl[4] = '{2,  384'(16'h8F90),    1'b0, 32'h0,         1'b1, 16'hEB9F};
    a_words = '{32'h0008_8B1F, 32'h0000_0000, 32'h044B_FF00, 32'hB7BE_4300, 32'h0000_01E8, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_i_tready", 32'(i_tready), 32'd0);
    check("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_o_tdata", o_tdata, 32'd0);
    check("rst_o_tlast_tkeep", {27'd0, o_tlast, o_tkeep}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      p.delete();
      for (int i = 0; i < tbl[t].len; i++) p.push_back(tbl[t].text[8*(tbl[t].len-1-i) +: 8]);
      rdy_div = (t % 2 == 0) ? 1 : 3;
      send_packet(p, 0, 1'b1, 1'b1);
      drain($sformatf("vec%0d_drain", t));
      if (tbl[t].has_crc) check_trailer($sformatf("vec%0d", t), tbl[t].crc, tbl[t].len);
      if (tbl[t].has_defl && last_member.size() >= 12)
        check($sformatf("vec%0d_deflate", t), {16'd0, last_member[10], last_member[11]}, {16'd0, tbl[t].defl});
    end

    rdy_div = 1;
    p.delete();
    p.push_back(8'h61);
    model_push(p);
    i_tvalid = 1'b1; i_tdata = 8'h61; i_tlast = 1'b1;
    n = 0;
    @(negedge clk);
    while (!i_tready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0;
    n = 0;
    while (!o_tvalid && n < 10) begin @(posedge clk); #1; n++; end
    check("first_word_latency_le4", 32'(n <= 4), 32'd1);
    drain("a_drain");
    check("a_word_count", 32'(last_words.size()), 32'd6);
    if (last_words.size() == 6)
      for (int i = 0; i < 6; i++) check($sformatf("a_word%0d", i), last_words[i], a_words[i]);

    foreach (a_words[r]) begin
      case (r)
        0: rdy_div = 1;
        1: rdy_div = 2;
        2: rdy_div = 3;
        3: rdy_div = 11;
        default: rdy_div = 51;
      endcase
      if (r > 4) break;
      m0 = members;
      for (int k = 0; k < 2; k++) begin
        p.delete();
        len = (rdy_div == 51) ? $urandom_range(60, 1) : $urandom_range(160, 1);
        for (int i = 0; i < len; i++) p.push_back(8'($urandom_range(255)));
        send_packet(p, 20, 1'b1, 1'b1);
      end
      drain($sformatf("rand_div%0d_drain", rdy_div));
      check($sformatf("rand_div%0d_members", rdy_div), 32'(members - m0), 32'd2);
      check_trailer($sformatf("rand_div%0d", rdy_div), ref_crc(p), p.size());
    end

    rdy_div = 2;
    sb_ignore = 1'b1;
    p.delete();
    for (int i = 0; i < 20; i++) p.push_back(8'($urandom_range(255)));
    send_packet(p, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_i_tready", 32'(i_tready), 32'd0);
    check("midrst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("midrst_o_tdata", o_tdata, 32'd0);
    check("midrst_o_tlast_tkeep", {27'd0, o_tlast, o_tkeep}, 32'd0);
    exp_q.delete();
    got_bytes.delete();
    got_words.delete();
    sb_ignore = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    p.delete();
    for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
    send_packet(p, 0, 1'b1, 1'b1);
    drain("postrst_drain");
    check_trailer("postrst", 32'hCBF4_3926, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gzip_compressor_top.md
GZIP_COMPRESSOR_TOP -- requirements
Module: gzip_compressor_top

Interface
REQ-001 SHALL have parameter SIMULATION, default 0: 1 enables simulation-only printing of per-packet CRC32 and byte count at i_tlast; no effect on synthesized logic or outputs.
REQ-002 SHALL have clk, input, 1: single clock; all logic on rising edge.
REQ-003 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have i_tready, output, 1: input AXI-stream ready.
REQ-005 SHALL have i_tvalid, input, 1: input byte valid.
REQ-006 SHALL have i_tdata, input, 8: input byte.
REQ-007 SHALL have i_tlast, input, 1: last byte of the input packet (file).
REQ-008 SHALL have o_tready, input, 1: output sink ready.
REQ-009 SHALL have o_tvalid, output, 1: output word valid.
REQ-010 SHALL have o_tdata, output, 32: output bytes, little-endian (first byte in [7:0]).
REQ-011 SHALL have o_tlast, output, 1: last word of a gzip member.
REQ-012 SHALL have o_tkeep, output, 4: byte enables; 4'b1111 on every non-last word; contiguous low bits (0001/0011/0111/1111) on the last word.

Function
REQ-013 Each input packet (one or more bytes, ended by i_tlast) SHALL produce exactly one complete RFC1952 gzip member as one output packet ending with o_tlast; packets SHALL NOT be interleaved or merged.
REQ-014 Header SHALL be the 10 bytes 1F 8B 08 00 00 00 00 00 00 FF (no flags, MTIME 0, XFL 0, OS 255).
REQ-015 Body SHALL be one deflate block, BFINAL=1, BTYPE=01 (fixed Huffman), literals only (no LZ77 matches), then end-of-block code 256.
REQ-016 Literal codes: 0..143 -> 8 bits, 0x30+lit; 144..255 -> 9 bits, 0x190+(lit-144); EOB -> 7 bits 0000000; Huffman codes emitted MSB-first, header fields LSB-first, bits packed LSB-first into bytes.
REQ-017 After EOB the stream SHALL be zero-padded to a byte boundary, then CRC32 (4 bytes LE), then ISIZE = byte count mod 2^32 (4 bytes LE).
REQ-018 CRC32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, one byte per cycle; restarted for every packet.
REQ-019 Datapath: 64-bit bit accumulator appending up to 9 bits/cycle; a 32-bit word is moved to the output register whenever ≥32 bits are held and the register is empty or being accepted.
REQ-020 Sustained throughput SHALL be 1 input byte/cycle while o_tready=1; i_tready SHALL drop only when the accumulator cannot absorb 9 more bits.
REQ-021 i_tready, once asserted, SHALL stay asserted until a transfer occurs (never withdrawn while i_tvalid=0 or while waiting).
REQ-022 While o_tvalid=1 and o_tready=0, o_tvalid, o_tdata, o_tlast, o_tkeep SHALL hold stable.
REQ-023 FSM: IDLE -> HEADER (on first accepted byte) -> DATA -> TAIL (EOB, pad, CRC, ISIZE after i_tlast byte) -> FLUSH (emit final partial word with o_tlast) -> IDLE; i_tready=0 in TAIL/FLUSH.
REQ-024 First output word SHALL be valid ≤4 cycles after the first input handshake when o_tready=1.

Reset
REQ-025 While rst=1: i_tready=0, o_tvalid=0, o_tlast=0, o_tkeep=0, o_tdata=0, FSM=IDLE, accumulator empty, CRC=0xFFFFFFFF, count=0.
REQ-026 Reset mid-packet SHALL discard the partial member; the next packet after rst deasserts SHALL produce a complete fresh member.

Verification
REQ-027 Single byte 'a' (0x61, tlast) -> words 0x00088B1F, 0x00000000, 0x044BFF00, 0xB7BE4300, 0x000001E8, 0x00000000 (tkeep 0001, tlast).
REQ-028 "123456789" -> member trailer CRC bytes 26 39 F4 CB, ISIZE 09 00 00 00; gunzip output equals input.
REQ-029 Random packets 1..100000 bytes, o_tready patterns always-1, 1-of-2, 1-of-3, 1-of-11, 1-of-51 -> every member decompresses bit-exact; CRC printed by bench matches trailer.
REQ-030 Bytes 0x8F and 0x90 -> 8-bit code 0xBF and 9-bit code 0x190 respectively at correct bit positions.
REQ-031 Protocol monitor throughout: no output change while stalled, no i_tready withdrawal before transfer, tkeep rules per REQ-012.
REQ-032 Assert rst mid-packet -> outputs reach reset values next cycle; following packet yields valid member.
